// File: rtl/uart_rx_frame_pkg.sv
// Shared UART frame definitions: state encodings and frame geometry.
// Used by both the receiver and the transmitter of this codebase.
package uart_rx_frame_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 12;
  // start + data + parity + stop
  localparam int unsigned STOP_BITS  = FRAME_BITS - DATA_BITS - 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_t;

  function automatic logic parity_bad(input logic [7:0] d, input logic p, input logic odd);
    return (^d) ^ p ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_frame_rxd_sync.sv
// Two-flop synchronizer for the serial line; both flops reset to the idle level.
module rxd_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 1 start, 8 data (LSB first), 1 parity, 2 stop bits.
// Delivers every frame with a one-clock valid strobe and sticky-until-next error flags.
module uart_rx_frame
  import uart_rx_frame_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic [2:0] state_test,
  output logic [7:0] cnt_test
);

  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] HALF = 8'(CLKS_PER_BIT / 2);
  localparam logic       ODD  = (PARITY_ODD != 0);

  logic       rxs;
  rx_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d, fr_q, fr_d;
  logic [7:0] data_d;
  logic       valid_d, perr_d, ferr_d;
  logic       sample, fr_now;

  rxd_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      fr_q       <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      fr_q       <= fr_d;
      data       <= data_d;
      valid      <= valid_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    fr_d    = fr_q;
    data_d  = data;
    valid_d = 1'b0;
    perr_d  = parity_err;
    ferr_d  = frame_err;
    sample  = (cnt_q == LAST);
    fr_now  = fr_q | ~rxs;

    // Samples after the start bit fall every CLKS_PER_BIT clocks; the counter
    // restarts at each sample point so LAST marks the next one.
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          cnt_d   = '0;
          idx_d   = '0;
          par_d   = 1'b0;
          fr_d    = 1'b0;
          state_d = (CLKS_PER_BIT == 1) ? ST_DATA : ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DATA: begin
        if (sample) begin
          cnt_d   = '0;
          shreg_d = {rxs, shreg_q[7:1]};
          if (idx_q == 3'(DATA_BITS - 1)) begin
            idx_d   = '0;
            state_d = ST_PARITY;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_PARITY: begin
        if (sample) begin
          cnt_d   = '0;
          par_d   = parity_bad(shreg_q, rxs, ODD);
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_STOP: begin
        if (sample) begin
          cnt_d = '0;
          fr_d  = fr_now;
          if (idx_q == 3'(STOP_BITS - 1)) begin
            idx_d   = '0;
            data_d  = shreg_q;
            perr_d  = par_q;
            ferr_d  = fr_now;
            valid_d = 1'b1;
            state_d = fr_now ? ST_WAIT_IDLE : ST_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WAIT_IDLE: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign state_test = state_q;
  assign cnt_test   = cnt_q;

endmodule

// File: doc/uart_rx_frame.md
UART_RX_FRAME -- requirements
Module: uart_rx_frame

Interface
REQ-001 Parameter CLKS_PER_BIT, default 1: clock cycles per serial bit; legal values 1..255.
REQ-002 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 clk  input  1  single clock; every register updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rxd  input  1  serial line; idles high.
REQ-006 data  output  8  last received byte.
REQ-007 valid  output  1  one-clk strobe: data and error flags are new.
REQ-008 parity_err  output  1  parity mismatch on the delivered frame; qualified by valid.
REQ-009 frame_err  output  1  at least one stop bit read 0; qualified by valid.
REQ-010 state_test  output  3  current FSM state, debug only.
REQ-011 cnt_test  output  8  bit-period counter, debug only.

Function
REQ-012 Frame format, fixed: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 2 stop bits (1); 12 bit periods in total.
REQ-013 rxd shall pass through a 2-flop synchronizer before any FSM use; the synchronized value is called rxs.
REQ-014 FSM states and encodings: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_IDLE=5.
REQ-015 IDLE: when rxs=0, go to START and clear the counter.
REQ-016 START, CLKS_PER_BIT=1: the start bit is taken as sampled at detection; go directly to DATA.
REQ-017 START, CLKS_PER_BIT>1: sample rxs at count CLKS_PER_BIT/2 (integer division). If 1, treat as a glitch and return to IDLE with no strobe. If 0, go to DATA.
REQ-018 Each later bit is sampled once, exactly CLKS_PER_BIT cycles after the previous sample point.
REQ-019 The counter wraps to 0 at each sample point.
REQ-020 DATA: shift the sampled bit into bit 7 of the shift register. After the 8th sample, go to PARITY.
REQ-021 PARITY: compute the XOR of the 8 data bits, the parity bit, and PARITY_ODD. A result of 1 sets the internal parity error. Then go to STOP.
REQ-022 STOP: sample 2 stop bits; any 0 sets the internal frame error. After the 2nd sample, register the outputs.
REQ-023 Output registration: data <= shift register; parity_err and frame_err <= internal flags; valid=1 for exactly one clk.
REQ-024 After STOP: go to IDLE if frame error=0, otherwise go to WAIT_IDLE.
REQ-025 WAIT_IDLE: remain until rxs=1, then go to IDLE. No start detection is allowed in this state.
REQ-026 A frame with errors is still delivered; data holds the bits as received.
REQ-027 data, parity_err and frame_err hold their values between strobes.
REQ-028 Latency, CLKS_PER_BIT=1: valid is asserted at the 14th rising edge after the first edge at which rxd=0 is captured (2 sync cycles + 12 bit periods). The next start bit can be detected in the same cycle as valid.
REQ-029 Back-to-back frames with zero idle gap shall all be received.

Reset
REQ-030 While rst=0: state=IDLE, counter=0, shift register=0, data=0x00, valid=0, parity_err=0, frame_err=0, both synchronizer flops=1.
REQ-031 Assertion of rst mid-frame aborts the frame; no strobe is produced for it.
REQ-032 After rst is released, the block resumes in IDLE; a line already low is treated as a new start bit.

Structure
REQ-033 The shared header uart_defs shall hold: state encodings, DATA_BITS=8, STOP_BITS=2, FRAME_BITS=12. The transmitter shall include the same header.
REQ-034 One sub-module, rxd_sync: a 2-flop synchronizer with asynchronous active-low reset to 1.

Verification
REQ-035 Normal byte, CLKS_PER_BIT=1: bits 0,1,0,0,0,0,0,1,0,0,1,1 (0x41, even parity 0) -> one valid pulse, data=0x41, parity_err=0, frame_err=0, at edge 14.
REQ-036 Parity error: 0x41 frame with parity bit=1 -> valid pulse, data=0x41, parity_err=1, frame_err=0.
REQ-037 Frame error: 0x41 frame with stop bits 0,0, then line held low 5 clks -> frame_err=1, state_test=5 for those 5 clks, and no further valid until rxd returns high.
REQ-038 Glitch, CLKS_PER_BIT=4: rxd low for 1 clk -> no valid; state_test returns to 0.
REQ-039 Loopback with the transmitter: 16 bytes from a file, one every 12 clks -> exactly 16 valid pulses whose data matches the file in order.
REQ-040 Reset mid-frame: rst=0 during data bit 4 -> outputs at reset values, no strobe; the next full 0x5A frame is received correctly.
